// File: rtl/sram_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_scan_pkg
// Description : Shared types and sizing helpers for the SRAM scan unit.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_scan_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_e;

  // Default skid FIFO depth
  localparam int SCAN_FIFO_DEPTH = 4;

  // Width needed to hold an occupancy value of 0..depth inclusive
  function automatic int scan_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sky130_sram_4kbyte_1rw1r_32x1024_8.sv
`default_nettype none
// ============================================================================
// Module      : sky130_sram_4kbyte_1rw1r_32x1024_8
// Description : Behavioural stand-in for the 1RW/1R SRAM macro. Port 0 reads
//               and byte-masked writes, port 1 reads with RD_LAT cycles of
//               latency. Storage is not reset, like the real array.
// Revision    : 1.0 - initial release
// ============================================================================
module sky130_sram_4kbyte_1rw1r_32x1024_8 #(
  parameter int NUM_WMASKS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  input  logic                  clk1,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1
);

  localparam int BYTE_W = DATA_WIDTH / NUM_WMASKS;

  logic [DATA_WIDTH-1:0] r_mem   [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_pipe1 [RD_LAT];

  // Port 0: byte-masked write or registered read
  always_ff @(posedge clk0) begin
    if (!csb0 && !web0) begin
      for (int b = 0; b < NUM_WMASKS; b++) begin
        if (wmask0[b]) r_mem[addr0][b*BYTE_W +: BYTE_W] <= din0[b*BYTE_W +: BYTE_W];
      end
    end else if (!csb0) begin
      dout0 <= r_mem[addr0];
    end
  end

  // Port 1: read captured at the select edge, then delayed to RD_LAT
  always_ff @(posedge clk1) begin
    if (!csb1) r_pipe1[0] <= r_mem[addr1];
    for (int i = 1; i < RD_LAT; i++) r_pipe1[i] <= r_pipe1[i-1];
  end

  assign dout1 = r_pipe1[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/sram_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sram_skid_fifo
// Description : Small synchronous FIFO absorbing read returns; valid/ready on
//               the pop side, occupancy exposed for credit accounting.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_skid_fifo
  import sram_scan_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = SCAN_FIFO_DEPTH
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  push,
  input  logic [DATA_WIDTH-1:0]                 push_data,
  output logic                                  pop_valid,
  input  logic                                  pop_ready,
  output logic [DATA_WIDTH-1:0]                 pop_data,
  output logic [scan_cnt_w(FIFO_DEPTH)-1:0]     count
);

  localparam int CNT_W = scan_cnt_w(FIFO_DEPTH);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_pop;

  assign pop_valid = (r_count != '0);
  assign w_pop     = pop_valid && pop_ready;
  assign pop_data  = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Pointer and occupancy tracking; push and pop may coincide
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push)  r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      case ({push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates them
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

  // Upstream credit accounting must never push into a full FIFO
  always_ff @(posedge clk) begin
    if (rst_n && push) assert (r_count < CNT_FULL);
  end

endmodule
`default_nettype wire

// File: rtl/sram_scan_unit.sv
`default_nettype none
// ============================================================================
// Module      : sram_scan_unit
// Description : SRAM macro wrapper. Port 0 is a host passthrough; port 1 is
//               driven by a base/limit/stride sequencer (one-shot/circular)
//               whose returns are streamed out through a skid FIFO.
//               FIFO_DEPTH must be at least RD_LAT+1.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_scan_unit
  import sram_scan_pkg::*;
#(
  parameter int NUM_WMASKS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = SCAN_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_limit,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  input  logic                  cfg_circ,
  input  logic                  start,
  input  logic                  stop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  collide
);

  localparam int CNT_W = scan_cnt_w(FIFO_DEPTH);
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W+1)'(FIFO_DEPTH);

  scan_state_e           r_state;
  logic [ADDR_WIDTH-1:0] r_addr1;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_limit;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic                  r_circ;
  logic                  r_done;
  logic                  r_cfg_err;
  logic                  r_collide;
  logic [RD_LAT-1:0]     r_lat_vld;

  logic                  w_issue;
  logic                  w_csb1;
  logic                  w_push;
  logic                  w_credit_ok;
  logic                  w_drained;
  logic [ADDR_WIDTH:0]   w_nxt;
  logic [CNT_W-1:0]      w_outstanding;
  logic [CNT_W-1:0]      w_fifo_count;
  logic [DATA_WIDTH-1:0] w_dout1;

  sky130_sram_4kbyte_1rw1r_32x1024_8 #(
    .NUM_WMASKS (NUM_WMASKS),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RD_LAT     (RD_LAT)
  ) u_sram (
    .clk0   (clk),
    .csb0   (csb0),
    .web0   (web0),
    .wmask0 (wmask0),
    .addr0  (addr0),
    .din0   (din0),
    .dout0  (dout0),
    .clk1   (clk),
    .csb1   (w_csb1),
    .addr1  (r_addr1),
    .dout1  (w_dout1)
  );

  sram_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_dout1),
    .pop_valid (rd_valid),
    .pop_ready (rd_ready),
    .pop_data  (rd_data),
    .count     (w_fifo_count)
  );

  // Reads in flight = set bits in the latency pipeline
  always_comb begin
    w_outstanding = '0;
    for (int i = 0; i < RD_LAT; i++) w_outstanding = w_outstanding + CNT_W'(r_lat_vld[i]);
  end

  // Issue only while every possible return still has a FIFO slot reserved
  assign w_credit_ok = (({1'b0, w_outstanding} + {1'b0, w_fifo_count}) < CREDIT_MAX);
  assign w_issue     = (r_state == ST_RUN) && w_credit_ok && !stop;
  assign w_csb1      = !w_issue;
  assign w_drained   = (w_outstanding == '0) && (w_fifo_count == '0);
  assign w_push      = r_lat_vld[RD_LAT-1];
  // One extra bit so an address step past the top of memory is seen as > limit
  assign w_nxt       = {1'b0, r_addr1} + {1'b0, r_stride};

  generate
    if (RD_LAT == 1) begin : g_lat_single
      // Single-stage return tracker
      always_ff @(posedge clk) begin
        if (!rst_n) r_lat_vld <= '0;
        else        r_lat_vld <= w_issue;
      end
    end else begin : g_lat_shift
      // Return tracker; the tail marks the cycle dout1 carries issued data
      always_ff @(posedge clk) begin
        if (!rst_n) r_lat_vld <= '0;
        else        r_lat_vld <= {r_lat_vld[RD_LAT-2:0], w_issue};
      end
    end
  endgenerate

  // Sequencer: config latch, address stepping and drain handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_addr1   <= '0;
      r_base    <= '0;
      r_limit   <= '0;
      r_stride  <= '0;
      r_circ    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_base <= cfg_limit) begin
              r_base   <= cfg_base;
              r_limit  <= cfg_limit;
              r_stride <= (cfg_stride == '0) ? ADDR_WIDTH'(1) : cfg_stride;
              r_circ   <= cfg_circ;
              r_addr1  <= cfg_base;
              r_state  <= ST_RUN;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (stop) begin
            r_state <= ST_DRAIN;
          end else if (w_issue) begin
            if (w_nxt > {1'b0, r_limit}) begin
              if (r_circ) r_addr1 <= r_base;
              else        r_state <= ST_DRAIN;
            end else begin
              r_addr1 <= w_nxt[ADDR_WIDTH-1:0];
            end
          end
        end
        ST_DRAIN: begin
          if (w_drained) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Flag a host write landing on the address port 1 reads this cycle
  always_ff @(posedge clk) begin
    if (!rst_n) r_collide <= 1'b0;
    else        r_collide <= !csb0 && !web0 && !w_csb1 && (addr0 == r_addr1);
  end

  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign cfg_err = r_cfg_err;
  assign collide = r_collide;

endmodule
`default_nettype wire
